// File: rtl/register_writeback_arbiter.sv
// Single write port for the integer register file: ALU results take priority, queued
// long-latency results fill idle slots, and a busy scoreboard tracks pending long writes.
module register_writeback_arbiter #(
  parameter int QUEUE_DEPTH  = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_alu_valid,
  input  logic [4:0]                     i_alu_rd_address,
  input  logic [31:0]                    i_alu_result,
  input  logic                           i_issue_valid,
  input  logic [4:0]                     i_issue_rd_address,
  input  logic                           i_long_valid,
  input  logic [4:0]                     i_long_rd_address,
  input  logic [31:0]                    i_long_result,
  output logic                           o_long_ready,
  input  logic [4:0]                     i_rs1_address,
  input  logic [4:0]                     i_rs2_address,
  input  logic [4:0]                     i_dest_address,
  output logic                           o_hazard,
  output logic                           o_alu_stall,
  output logic [31:0]                    o_rd,
  output logic [4:0]                     o_rd_address,
  output logic                           o_rd_write_enable,
  output logic [31:0]                    o_busy_vector,
  output logic [$clog2(QUEUE_DEPTH):0]   o_queue_count
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    r_q_addr [QUEUE_DEPTH];
  logic [31:0]   r_q_data [QUEUE_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_busy;
  logic [SW-1:0] r_starve;
  logic          r_alu_stall;
  logic [31:0]   r_rd;
  logic [4:0]    r_rd_address;
  logic          r_rd_write_enable;

  logic          w_alu_win;
  logic          w_queue_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_issue_set;
  logic [4:0]    w_head_addr;
  logic [31:0]   w_head_data;
  logic [31:0]   w_busy_next;
  logic          w_starve_reach;

  assign w_alu_win     = i_alu_valid && (i_alu_rd_address != 5'd0);
  assign w_queue_empty = (r_count == '0);
  assign w_pop         = !w_alu_win && !w_queue_empty;
  assign o_long_ready  = (r_count != CW'(QUEUE_DEPTH));
  assign w_push        = i_long_valid && o_long_ready && (i_long_rd_address != 5'd0);
  assign w_issue_set   = i_issue_valid && (i_issue_rd_address != 5'd0);
  assign w_head_addr   = r_q_addr[r_rd_ptr];
  assign w_head_data   = r_q_data[r_rd_ptr];

  // The counter saturates, so reaching the limit on this edge means it is one short now.
  assign w_starve_reach = !w_queue_empty && w_alu_win &&
                          (r_starve >= SW'(STARVE_LIMIT - 1));

  // Clear from the pop first, then the issue set, so a same-edge set wins.
  always_comb begin
    w_busy_next = r_busy;
    if (w_pop) w_busy_next[w_head_addr] = 1'b0;
    if (w_issue_set) w_busy_next[i_issue_rd_address] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_q_addr[r_wr_ptr] <= i_long_rd_address;
      r_q_data[r_wr_ptr] <= i_long_result;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr          <= '0;
      r_rd_ptr          <= '0;
      r_count           <= '0;
      r_busy            <= '0;
      r_starve          <= '0;
      r_alu_stall       <= 1'b0;
      r_rd              <= '0;
      r_rd_address      <= '0;
      r_rd_write_enable <= 1'b0;
    end else begin
      if (w_alu_win) begin
        r_rd         <= i_alu_result;
        r_rd_address <= i_alu_rd_address;
      end else if (w_pop) begin
        r_rd         <= w_head_data;
        r_rd_address <= w_head_addr;
      end
      r_rd_write_enable <= w_alu_win || w_pop;

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_busy  <= w_busy_next;

      if (w_pop || w_queue_empty) begin
        r_starve <= '0;
      end else if (w_alu_win && (r_starve != SW'(STARVE_LIMIT))) begin
        r_starve <= r_starve + 1'b1;
      end

      if (w_pop) begin
        r_alu_stall <= 1'b0;
      end else if (w_starve_reach) begin
        r_alu_stall <= 1'b1;
      end
    end
  end

  // Re-issuing to a busy register is only legal when its pending result retires this edge.
  always_ff @(posedge i_clock) begin
    if (!i_reset && w_issue_set) begin
      assert (!(r_busy[i_issue_rd_address] &&
                !(w_pop && (w_head_addr == i_issue_rd_address))));
    end
  end

  assign o_hazard          = r_busy[i_rs1_address] | r_busy[i_rs2_address] |
                             r_busy[i_dest_address];
  assign o_alu_stall       = r_alu_stall;
  assign o_rd              = r_rd;
  assign o_rd_address      = r_rd_address;
  assign o_rd_write_enable = r_rd_write_enable;
  assign o_busy_vector     = r_busy;
  assign o_queue_count     = r_count;

endmodule

// File: tb/tb_register_writeback_arbiter.sv
// Scoreboard bench for register_writeback_arbiter: a queue-based reference model predicts
// every register-file write and the per-cycle status outputs.
module tb_register_writeback_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic        clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_alu_valid = 1'b0;
  logic [4:0]  i_alu_rd_address = '0;
  logic [31:0] i_alu_result = '0;
  logic        i_issue_valid = 1'b0;
  logic [4:0]  i_issue_rd_address = '0;
  logic        i_long_valid = 1'b0;
  logic [4:0]  i_long_rd_address = '0;
  logic [31:0] i_long_result = '0;
  logic [4:0]  i_rs1_address = '0;
  logic [4:0]  i_rs2_address = '0;
  logic [4:0]  i_dest_address = '0;
  logic        o_long_ready;
  logic        o_hazard;
  logic        o_alu_stall;
  logic [31:0] o_rd;
  logic [4:0]  o_rd_address;
  logic        o_rd_write_enable;
  logic [31:0] o_busy_vector;
  logic [2:0]  o_queue_count;

  always #5 clock = ~clock;

  register_writeback_arbiter #(.QUEUE_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .i_clock(clock), .i_reset(i_reset),
    .i_alu_valid(i_alu_valid), .i_alu_rd_address(i_alu_rd_address), .i_alu_result(i_alu_result),
    .i_issue_valid(i_issue_valid), .i_issue_rd_address(i_issue_rd_address),
    .i_long_valid(i_long_valid), .i_long_rd_address(i_long_rd_address),
    .i_long_result(i_long_result), .o_long_ready(o_long_ready),
    .i_rs1_address(i_rs1_address), .i_rs2_address(i_rs2_address),
    .i_dest_address(i_dest_address), .o_hazard(o_hazard), .o_alu_stall(o_alu_stall),
    .o_rd(o_rd), .o_rd_address(o_rd_address), .o_rd_write_enable(o_rd_write_enable),
    .o_busy_vector(o_busy_vector), .o_queue_count(o_queue_count)
  );

  typedef struct {logic [4:0] addr; logic [31:0] data;} entry_t;
  typedef struct {logic [4:0] addr; logic [31:0] data; int due;} wr_t;

  entry_t      mq[$];
  wr_t         expQ[$];
  logic [31:0] mBusy = '0;
  int          mStarve = 0;
  logic        mStall = 1'b0;
  int          cycleNo = 0;
  int          nCompared = 0;
  int          nMismatched = 0;
  bit          monitorOn = 1'b0;
  wr_t         monEntry;

  always @(posedge clock) cycleNo++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cycleNo);
    end
  endtask

  // Drive one cycle of inputs, check status outputs, then advance the reference model.
  task automatic applyStimulus(input bit aluV, input logic [4:0] aluA, input logic [31:0] aluD,
                               input bit issV, input logic [4:0] issA,
                               input bit lngV, input logic [4:0] lngA, input logic [31:0] lngD,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] dst);
    bit     ready;
    bit     popped;
    int     preSize;
    entry_t h;
    wr_t    w;
    i_alu_valid = aluV;  i_alu_rd_address = aluA;  i_alu_result = aluD;
    i_issue_valid = issV;  i_issue_rd_address = issA;
    i_long_valid = lngV;  i_long_rd_address = lngA;  i_long_result = lngD;
    i_rs1_address = rs1;  i_rs2_address = rs2;  i_dest_address = dst;
    #1;
    preSize = mq.size();
    ready   = (preSize < DEPTH);
    checkOutput("long_ready", 32'(o_long_ready), 32'(ready));
    checkOutput("queue_count", 32'(o_queue_count), 32'(preSize));
    checkOutput("busy_vector", o_busy_vector, mBusy);
    checkOutput("alu_stall", 32'(o_alu_stall), 32'(mStall));
    checkOutput("hazard", 32'(o_hazard), 32'(mBusy[rs1] | mBusy[rs2] | mBusy[dst]));

    popped = 1'b0;
    if (aluV && aluA != 5'd0) begin
      w.addr = aluA;  w.data = aluD;  w.due = cycleNo + 1;
      expQ.push_back(w);
    end else if (preSize > 0) begin
      h = mq.pop_front();
      popped = 1'b1;
      mBusy[h.addr] = 1'b0;
      w.addr = h.addr;  w.data = h.data;  w.due = cycleNo + 1;
      expQ.push_back(w);
    end
    if (lngV && ready && lngA != 5'd0) mq.push_back('{addr: lngA, data: lngD});
    if (issV && issA != 5'd0) mBusy[issA] = 1'b1;
    if (popped || preSize == 0) mStarve = 0;
    else if (aluV && aluA != 5'd0 && mStarve < LIMIT) mStarve++;
    if (popped) mStall = 1'b0;
    else if (mStarve >= LIMIT) mStall = 1'b1;

    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    i_reset = 1'b1;
    i_alu_valid = 1'b0;  i_issue_valid = 1'b0;  i_long_valid = 1'b0;
    i_rs1_address = '0;  i_rs2_address = '0;  i_dest_address = '0;
    repeat (2) @(posedge clock);
    #1;
    i_reset = 1'b0;
    mq.delete();
    expQ.delete();
    mBusy = '0;
    mStarve = 0;
    mStall = 1'b0;
  endtask

  // Monitor: every write strobe must match the oldest predicted write, in its predicted cycle.
  always @(negedge clock) begin
    if (monitorOn) begin
      if (o_rd_write_enable === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_write", 32'(o_rd_write_enable), 32'd0);
        end else begin
          monEntry = expQ.pop_front();
          checkOutput("write_cycle", 32'(cycleNo), 32'(monEntry.due));
          checkOutput("rd_address", 32'(o_rd_address), 32'(monEntry.addr));
          checkOutput("rd", o_rd, monEntry.data);
        end
      end else if (expQ.size() > 0 && expQ[0].due <= cycleNo) begin
        monEntry = expQ.pop_front();
        checkOutput("missing_write", 32'(o_rd_write_enable), 32'd1);
      end
    end
  end

  initial begin
    int          bl[$];
    bit          aluV, issV, lngV;
    logic [4:0]  aluA, issA, lngA;

    $display("[TB] start");
    doReset();
    monitorOn = 1'b1;
    checkOutput("reset_rd", o_rd, 32'd0);
    checkOutput("reset_rd_address", 32'(o_rd_address), 32'd0);
    checkOutput("reset_enable", 32'(o_rd_write_enable), 32'd0);
    idle(2);

    $display("[TB] single ALU write");
    applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("alu_enable", 32'(o_rd_write_enable), 32'd1);
    checkOutput("alu_address", 32'(o_rd_address), 32'd5);
    checkOutput("alu_data", o_rd, 32'hDEADBEEF);
    idle(1);
    checkOutput("alu_one_cycle", 32'(o_rd_write_enable), 32'd0);

    $display("[TB] long result with hazard");
    applyStimulus(0, 0, 0, 1, 5'd7, 0, 0, 0, 5'd7, 0, 0);
    checkOutput("busy7_set", 32'(o_busy_vector[7]), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 5'd7, 32'h12345678, 5'd7, 0, 0);
    checkOutput("long_not_yet", 32'(o_rd_write_enable), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0, 0);
    checkOutput("long_written", o_rd, 32'h12345678);
    checkOutput("busy7_clear", 32'(o_busy_vector[7]), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0, 0);
    checkOutput("hazard7_clear", 32'(o_hazard), 32'd0);

    $display("[TB] fill queue under ALU pressure");
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1, 5'd1, 32'(i), 0, 0, 1, 5'(10 + i), 32'(100 + i), 0, 0, 0);
    checkOutput("full_count", 32'(o_queue_count), 32'(DEPTH));
    checkOutput("full_not_ready", 32'(o_long_ready), 32'd0);
    checkOutput("stall_set", 32'(o_alu_stall), 32'd1);
    applyStimulus(1, 5'd1, 32'hA5A5A5A5, 0, 0, 1, 5'd20, 32'h55, 0, 0, 0);
    idle(DEPTH + 1);
    checkOutput("drained_count", 32'(o_queue_count), 32'd0);
    checkOutput("stall_cleared", 32'(o_alu_stall), 32'd0);

    $display("[TB] issue and retire same register same edge");
    applyStimulus(0, 0, 0, 1, 5'd9, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 5'd9, 32'h0000AAAA, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 5'd9, 0, 0, 0, 0, 0, 0);
    checkOutput("busy9_set_wins", 32'(o_busy_vector[9]), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 5'd9, 32'h0000BBBB, 0, 0, 0);
    idle(2);
    checkOutput("busy9_cleared", 32'(o_busy_vector[9]), 32'd0);

    $display("[TB] writes to x0");
    applyStimulus(1, 5'd0, 32'h11111111, 1, 5'd0, 1, 5'd0, 32'h22222222, 0, 0, 0);
    checkOutput("x0_no_enable", 32'(o_rd_write_enable), 32'd0);
    checkOutput("x0_no_queue", 32'(o_queue_count), 32'd0);
    checkOutput("x0_no_busy", o_busy_vector, 32'd0);
    idle(1);

    $display("[TB] reset with queued entries");
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 5'd2, 32'(i), 1, 5'(20 + i), 1, 5'(20 + i), 32'(200 + i), 0, 0, 0);
    checkOutput("queued_three", 32'(o_queue_count), 32'd3);
    doReset();
    checkOutput("reset_queue", 32'(o_queue_count), 32'd0);
    checkOutput("reset_busy", o_busy_vector, 32'd0);
    checkOutput("reset_no_write", 32'(o_rd_write_enable), 32'd0);
    idle(3);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      bl.delete();
      for (int r = 1; r < 32; r++) if (mBusy[r]) bl.push_back(r);
      aluV = ($urandom_range(0, 99) < 40);
      aluA = 5'($urandom_range(0, 31));
      issA = 5'($urandom_range(0, 31));
      issV = ($urandom_range(0, 2) == 0) && !mBusy[issA];
      lngV = ($urandom_range(0, 99) < 50);
      if (bl.size() > 0 && $urandom_range(0, 3) != 0)
        lngA = 5'(bl[$urandom_range(0, bl.size() - 1)]);
      else
        lngA = 5'($urandom_range(0, 31));
      applyStimulus(aluV, aluA, $urandom, issV, issA, lngV, lngA, $urandom,
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)));
    end
    idle(DEPTH + 3);
    checkOutput("pending_writes", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
